// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encodings, ALU codes and the control bundle shared by the
// decoder, ALU and pipeline.
package cpu_pkg;
    localparam logic [8:0] OP_NOP  = 9'h000;
    localparam logic [8:0] OP_SETC = 9'h001;
    localparam logic [8:0] OP_CLRC = 9'h002;
    localparam logic [8:0] OP_NOT  = 9'h020;
    localparam logic [8:0] OP_INC  = 9'h021;
    localparam logic [8:0] OP_DEC  = 9'h022;
    localparam logic [8:0] OP_OUT  = 9'h023;
    localparam logic [8:0] OP_IN   = 9'h024;
    localparam logic [8:0] OP_MOV  = 9'h040;
    localparam logic [8:0] OP_ADD  = 9'h041;
    localparam logic [8:0] OP_SUB  = 9'h042;
    localparam logic [8:0] OP_AND  = 9'h043;
    localparam logic [8:0] OP_OR   = 9'h044;
    localparam logic [8:0] OP_SHL  = 9'h045;
    localparam logic [8:0] OP_SHR  = 9'h046;
    localparam logic [8:0] OP_PUSH = 9'h060;
    localparam logic [8:0] OP_POP  = 9'h061;
    localparam logic [8:0] OP_LDM  = 9'h062;
    localparam logic [8:0] OP_LDD  = 9'h063;
    localparam logic [8:0] OP_STD  = 9'h064;
    localparam logic [8:0] OP_JZ   = 9'h080;
    localparam logic [8:0] OP_JN   = 9'h081;
    localparam logic [8:0] OP_JC   = 9'h082;
    localparam logic [8:0] OP_JMP  = 9'h084;
    localparam logic [8:0] OP_CALL = 9'h086;
    localparam logic [8:0] OP_RET  = 9'h088;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_SETC = 4'b0001;
    localparam logic [3:0] ALU_CLRC = 4'b0010;
    localparam logic [3:0] ALU_MOV  = 4'b0011;
    localparam logic [3:0] ALU_PASS = 4'b0100;
    localparam logic [3:0] ALU_NOT  = 4'b0101;
    localparam logic [3:0] ALU_INC  = 4'b0110;
    localparam logic [3:0] ALU_DEC  = 4'b0111;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1001;
    localparam logic [3:0] ALU_AND  = 4'b1010;
    localparam logic [3:0] ALU_OR   = 4'b1011;
    localparam logic [3:0] ALU_SHL  = 4'b1100;
    localparam logic [3:0] ALU_SHR  = 4'b1101;

    typedef struct packed {
        logic       branch;
        logic       data_read;
        logic       data_write;
        logic       dmr;
        logic       dmw;
        logic       ioe;
        logic       ior;
        logic       iow;
        logic       stack_operation;
        logic       push_pop;
        logic       pass_immediate;
        logic       write_sp;
        logic [3:0] alu;
    } ctrl_t;

    // Flag masks line up with the ctrl_t field order above alu.
    localparam logic [11:0] F_BR  = 12'h800;
    localparam logic [11:0] F_DR  = 12'h400;
    localparam logic [11:0] F_DW  = 12'h200;
    localparam logic [11:0] F_DMR = 12'h100;
    localparam logic [11:0] F_DMW = 12'h080;
    localparam logic [11:0] F_IOE = 12'h040;
    localparam logic [11:0] F_IOR = 12'h020;
    localparam logic [11:0] F_IOW = 12'h010;
    localparam logic [11:0] F_SO  = 12'h008;
    localparam logic [11:0] F_PP  = 12'h004;
    localparam logic [11:0] F_PI  = 12'h002;
    localparam logic [11:0] F_WSP = 12'h001;

    function automatic ctrl_t mk_ctrl(input logic [11:0] f, input logic [3:0] a);
        return ctrl_t'({f, a});
    endfunction
endpackage

// File: rtl/cu.sv
// cu: combinational opcode decoder with a sticky illegal-opcode flag.
module cu
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] opcode,
    output logic       branch,
    output logic       data_read,
    output logic       data_write,
    output logic       DMR,
    output logic       DMW,
    output logic       IOE,
    output logic       IOR,
    output logic       IOW,
    output logic       stack_operation,
    output logic       push_pop,
    output logic       pass_immediate,
    output logic       write_sp,
    output logic [3:0] alu_function,
    output logic       illegal_op
);
    ctrl_t w_ctrl;
    ctrl_t w_out;
    logic  w_legal;
    logic  r_illegal;

    always_comb begin
        w_ctrl  = '0;
        w_legal = 1'b1;
        case (opcode)
            OP_NOP:  w_ctrl = mk_ctrl(12'h000, ALU_NOP);
            OP_SETC: w_ctrl = mk_ctrl(12'h000, ALU_SETC);
            OP_CLRC: w_ctrl = mk_ctrl(12'h000, ALU_CLRC);
            OP_NOT:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_NOT);
            OP_INC:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_INC);
            OP_DEC:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_DEC);
            OP_OUT:  w_ctrl = mk_ctrl(F_DR | F_IOE | F_IOW, ALU_PASS);
            OP_IN:   w_ctrl = mk_ctrl(F_DW | F_IOE | F_IOR, ALU_NOP);
            OP_MOV:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_MOV);
            OP_ADD:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_ADD);
            OP_SUB:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_SUB);
            OP_AND:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_AND);
            OP_OR:   w_ctrl = mk_ctrl(F_DR | F_DW, ALU_OR);
            OP_SHL:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_SHL);
            OP_SHR:  w_ctrl = mk_ctrl(F_DR | F_DW, ALU_SHR);
            OP_PUSH: w_ctrl = mk_ctrl(F_DR | F_DMW | F_SO | F_PP | F_WSP, ALU_PASS);
            OP_POP:  w_ctrl = mk_ctrl(F_DW | F_DMR | F_SO | F_WSP, ALU_NOP);
            OP_LDM:  w_ctrl = mk_ctrl(F_DW | F_DMR | F_PI, ALU_MOV);
            OP_LDD:  w_ctrl = mk_ctrl(F_DR | F_DW | F_DMR, ALU_MOV);
            OP_STD:  w_ctrl = mk_ctrl(F_DR | F_DMW, ALU_MOV);
            OP_JZ, OP_JN, OP_JC: w_ctrl = mk_ctrl(F_BR | F_DR, ALU_PASS);
            OP_JMP, OP_CALL:     w_ctrl = mk_ctrl(F_BR, ALU_PASS);
            OP_RET:  w_ctrl = mk_ctrl(F_BR, ALU_NOP);
            default: w_legal = 1'b0;
        endcase
    end

    // Reset masks the decode asynchronously, independent of the clock.
    assign w_out = rst ? '0 : w_ctrl;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_illegal <= 1'b0;
        else if (!w_legal)
            r_illegal <= 1'b1;

    assign branch          = w_out.branch;
    assign data_read       = w_out.data_read;
    assign data_write      = w_out.data_write;
    assign DMR             = w_out.dmr;
    assign DMW             = w_out.dmw;
    assign IOE             = w_out.ioe;
    assign IOR             = w_out.ior;
    assign IOW             = w_out.iow;
    assign stack_operation = w_out.stack_operation;
    assign push_pop        = w_out.push_pop;
    assign pass_immediate  = w_out.pass_immediate;
    assign write_sp        = w_out.write_sp;
    assign alu_function    = w_out.alu;
    assign illegal_op      = r_illegal;
endmodule

// File: tb/tb_cu.sv
// tb_cu: directed-vector bench for the cu decoder and its sticky illegal flag.
`timescale 1ns/1ps
module tb_cu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] opcode = 9'h041;
    logic       branch, data_read, data_write, DMR, DMW, IOE, IOR, IOW;
    logic       stack_operation, push_pop, pass_immediate, write_sp, illegal_op;
    logic [3:0] alu_function;
    int         errs = 0;
    int         checks = 0;

    cu dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .branch(branch), .data_read(data_read), .data_write(data_write),
        .DMR(DMR), .DMW(DMW), .IOE(IOE), .IOR(IOR), .IOW(IOW),
        .stack_operation(stack_operation), .push_pop(push_pop),
        .pass_immediate(pass_immediate), .write_sp(write_sp),
        .alu_function(alu_function), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {branch,data_read,data_write,DMR,DMW,IOE,IOR,IOW,stack_op,push_pop,pass_imm,write_sp,alu}
    wire [15:0] w_dec = {branch, data_read, data_write, DMR, DMW, IOE, IOR, IOW,
                         stack_operation, push_pop, pass_immediate, write_sp, alu_function};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [8:0]  ops[26] = '{9'h000, 9'h001, 9'h002, 9'h020, 9'h021, 9'h022, 9'h023,
                             9'h024, 9'h040, 9'h041, 9'h042, 9'h043, 9'h044, 9'h045,
                             9'h046, 9'h060, 9'h061, 9'h062, 9'h063, 9'h064, 9'h080,
                             9'h081, 9'h082, 9'h084, 9'h086, 9'h088};
    logic [15:0] exps[26] = '{16'h0000, 16'h0001, 16'h0002, 16'h6005, 16'h6006, 16'h6007,
                              16'h4504, 16'h2600, 16'h6003, 16'h6008, 16'h6009, 16'h600A,
                              16'h600B, 16'h600C, 16'h600D, 16'h48D4, 16'h3090, 16'h3023,
                              16'h7003, 16'h4803, 16'hC004, 16'hC004, 16'hC004, 16'h8004,
                              16'h8004, 16'h8000};

    initial begin
        #3;
        chk("reset_dec", w_dec, 16'h0000);
        chk("reset_ill", {15'd0, illegal_op}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("release_add", w_dec, 16'h6008);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            opcode = ops[i];
            #2 chk($sformatf("sweep_%h", ops[i]), w_dec, exps[i]);
        end
        @(negedge clk);
        chk("sweep_no_ill", {15'd0, illegal_op}, 16'h0000);
        opcode = 9'h060;
        #2 chk("push", w_dec, 16'h48D4);
        opcode = 9'h061;
        #1 chk("pop", w_dec, 16'h3090);
        @(negedge clk);
        opcode = 9'h0FF;
        #1 chk("undef_dec", w_dec, 16'h0000);
        chk("undef_ill_pre", {15'd0, illegal_op}, 16'h0000);
        @(posedge clk);
        #1 chk("undef_ill", {15'd0, illegal_op}, 16'h0001);
        opcode = 9'h041;
        #1 chk("undef_add", w_dec, 16'h6008);
        @(negedge clk);
        chk("undef_sticky", {15'd0, illegal_op}, 16'h0001);
        #1 rst = 1'b1;
        #1 chk("async_rst_dec", w_dec, 16'h0000);
        chk("async_rst_ill", {15'd0, illegal_op}, 16'h0000);
        #1 rst = 1'b0;
        #1 chk("after_rst_dec", w_dec, 16'h6008);
        chk("after_rst_ill", {15'd0, illegal_op}, 16'h0000);
        @(negedge clk);
        opcode = 9'h141;
        #1 chk("bit8_dec", w_dec, 16'h0000);
        chk("bit8_ill_pre", {15'd0, illegal_op}, 16'h0000);
        @(posedge clk);
        #1 chk("bit8_ill", {15'd0, illegal_op}, 16'h0001);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cu.md
CU -- requirements
Module: cu

Interface
REQ-001 Parameters: none; opcode encodings and ALU codes are package constants.
REQ-002 clk  input  1  single clock; only the sticky illegal flag is clocked.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  9  instruction opcode; bits[7:5] = class, bits[4:0] = function, bit[8] = 0 for legal opcodes.
REQ-005 branch  output  1  instruction is a branch/jump/call/return.
REQ-006 data_read  output  1  register-file source read needed.
REQ-007 data_write  output  1  register-file destination write.
REQ-008 DMR  output  1  data-memory read.
REQ-009 DMW  output  1  data-memory write.
REQ-010 IOE  output  1  I/O port enable.
REQ-011 IOR  output  1  I/O read (IN).
REQ-012 IOW  output  1  I/O write (OUT).
REQ-013 stack_operation  output  1  memory address comes from SP.
REQ-014 push_pop  output  1  1 = push, 0 = pop; valid only with stack_operation.
REQ-015 pass_immediate  output  1  route the immediate operand to the result.
REQ-016 write_sp  output  1  update SP.
REQ-017 alu_function  output  4  ALU operation select.
REQ-018 illegal_op  output  1  sticky flag; set once an undefined opcode is decoded.

Function
REQ-019 All decode outputs are purely combinational from opcode; they settle within the same cycle and do not depend on clk.
REQ-020 Asserted control bits and alu_function per opcode. Every control bit not listed is 0.
- NOP 0x000: none; alu 0000
- SETC 0x001: none; alu 0001
- CLRC 0x002: none; alu 0010
- NOT 0x020: data_read, data_write; alu 0101
- INC 0x021: data_read, data_write; alu 0110
- DEC 0x022: data_read, data_write; alu 0111
- OUT 0x023: data_read, IOE, IOW; alu 0100
- IN 0x024: data_write, IOE, IOR; alu 0000
- MOV 0x040: data_read, data_write; alu 0011
- ADD 0x041: data_read, data_write; alu 1000
- SUB 0x042: data_read, data_write; alu 1001
- AND 0x043: data_read, data_write; alu 1010
- OR 0x044: data_read, data_write; alu 1011
- SHL 0x045: data_read, data_write; alu 1100
- SHR 0x046: data_read, data_write; alu 1101
- PUSH 0x060: data_read, DMW, stack_operation, push_pop, write_sp; alu 0100
- POP 0x061: data_write, DMR, stack_operation, write_sp; alu 0000
- LDM 0x062: data_write, DMR, pass_immediate; alu 0011
- LDD 0x063: data_read, data_write, DMR; alu 0011
- STD 0x064: data_read, DMW; alu 0011
- JZ 0x080, JN 0x081, JC 0x082: branch, data_read; alu 0100
- JMP 0x084, CALL 0x086: branch; alu 0100
- RET 0x088: branch; alu 0000
REQ-021 Any opcode not listed, including any opcode with bit[8] = 1, decodes exactly as NOP (all 0, alu 0000).
REQ-022 On the next clk rising edge after an undefined opcode is present, illegal_op is set to 1 and remains 1 until reset.
REQ-023 Mutual exclusions hold for every opcode:
- DMR and DMW are never both 1.
- IOR and IOW are never both 1.
- push_pop = 1 only when stack_operation = 1.

Reset
REQ-024 While rst = 1, all decode outputs are forced to the NOP pattern asynchronously and illegal_op is cleared to 0, regardless of opcode.
REQ-025 After rst deasserts, the decode outputs reflect opcode immediately; illegal_op resumes updating at the next clk edge.

Structure
REQ-026 The 9-bit opcode constants, 4-bit ALU code constants and the control-bundle typedef belong in a shared package cpu_pkg, also used by the ALU and pipeline.
REQ-027 The block is a single module using a case-based decoder; no sub-module is required.

Verification
REQ-028 All-opcode sweep: for each legal opcode, hold 10 ns -> every output matches the REQ-020 row exactly.
REQ-029 PUSH then POP: opcode 0x060 -> DMW=1, stack_operation=1, push_pop=1, write_sp=1, alu 0100; then 0x061 -> DMR=1, data_write=1, push_pop=0, alu 0000.
REQ-030 Undefined opcode: opcode 0x0FF, then one clk edge -> all decode outputs 0, alu 0000, illegal_op=1; change opcode to 0x041 -> illegal_op stays 1.
REQ-031 Asynchronous reset: opcode 0x041 with rst pulsed mid-cycle -> outputs drop to the NOP pattern and illegal_op=0 without a clk edge; after release, data_read=1, data_write=1, alu 1000.
REQ-032 Bit[8] set: opcode 0x141 -> decodes as NOP; illegal_op=1 after the next clk edge.
